// File: rtl/zap_regf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zap_regf_write_scheduler
// Purpose  : Schedules register-file writebacks from the execute result
//            stream (port A) and the memory-load return stream (port B).
//            Port B is buffered in a small FIFO; same-cycle A+B writes are
//            paired onto write ports 0 and 1. A PC write stalls further issue
//            until the clear-from-writeback flushes the machine.
// Ports    : i_clk, i_reset_n         clock, async active-low reset
//            i_a_*/o_a_ready          execute writeback request
//            i_b_*/o_b_ready          load-return writeback request
//            i_cpsr                   flags driven on B-only issue
//            i_stall, i_clear         downstream stall, writeback clear
//            o_valid, o_wr_*, o_flags, o_flag_update, o_mem_load
//                                     registered register-file write port
//            o_pending                FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module zap_regf_write_scheduler #(
  parameter  int PHY_REGS   = 46,
  parameter  int FLAG_WDT   = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  int RAZ_INDEX  = 45,
  parameter  int ARCH_PC    = 15,
  localparam int IW         = $clog2(PHY_REGS),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [IW-1:0]       i_a_index,
  input  logic [31:0]         i_a_data,
  input  logic [FLAG_WDT-1:0] i_a_flags,
  input  logic                i_a_flag_update,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [IW-1:0]       i_b_index,
  input  logic [31:0]         i_b_data,
  input  logic [31:0]         i_cpsr,
  input  logic                i_stall,
  input  logic                i_clear,
  output logic                o_valid,
  output logic [IW-1:0]       o_wr_index,
  output logic [31:0]         o_wr_data,
  output logic [FLAG_WDT-1:0] o_flags,
  output logic                o_flag_update,
  output logic [IW-1:0]       o_wr_index_1,
  output logic [31:0]         o_wr_data_1,
  output logic                o_mem_load,
  output logic [CW-1:0]       o_pending
);

  localparam int            PW       = CW - 1;
  localparam logic [IW-1:0] PC_IDX   = IW'(ARCH_PC);
  localparam logic [IW-1:0] RAZ_IDX  = IW'(RAZ_INDEX);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_WAIT_CLR = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Port-B buffer
  logic [IW-1:0] idx_mem_q  [FIFO_DEPTH];
  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Registered write interface
  logic                valid_q, valid_d;
  logic [IW-1:0]       wr_index_q, wr_index_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [FLAG_WDT-1:0] flags_q, flags_d;
  logic                flag_update_q, flag_update_d;
  logic [IW-1:0]       wr_index_1_q, wr_index_1_d;
  logic [31:0]         wr_data_1_q, wr_data_1_d;
  logic                mem_load_q, mem_load_d;

  logic          empty, full, run, hazard, pop, push, a_acc;
  logic [IW-1:0] head_idx;
  logic [31:0]   head_data;

  // Handshake and FIFO control
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    head_idx  = idx_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    run       = (state_q == ST_RUN);
    // A head targeting the same register as A, or targeting PC, must retire
    // on its own before A can proceed.
    hazard    = !empty && ((head_idx == i_a_index) || (head_idx == PC_IDX));
    o_a_ready = run && !i_stall && !i_clear && !hazard;
    // Any issue cycle with a non-empty FIFO retires the head.
    pop       = run && !i_stall && !empty;
    o_b_ready = !full || pop;
    a_acc     = i_a_valid && o_a_ready;
    push      = i_b_valid && o_b_ready && !i_clear;
    o_pending = count_q;
  end

  // Pointer / occupancy next state; clear flushes everything in flight.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Issue selection; outputs hold under stall.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    wr_index_d    = wr_index_q;
    wr_data_d     = wr_data_q;
    flags_d       = flags_q;
    flag_update_d = flag_update_q;
    wr_index_1_d  = wr_index_1_q;
    wr_data_1_d   = wr_data_1_q;
    mem_load_d    = mem_load_q;
    if (i_clear) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (!i_stall) begin
      valid_d = 1'b0;
      if (run) begin
        if (a_acc) begin
          valid_d       = 1'b1;
          wr_index_d    = i_a_index;
          wr_data_d     = i_a_data;
          flags_d       = i_a_flags;
          flag_update_d = i_a_flag_update;
          mem_load_d    = !empty;
          if (!empty) begin
            wr_index_1_d = head_idx;
            wr_data_1_d  = head_data;
          end
        end else if (!empty) begin
          // B-only: port 0 is parked on the read-as-zero register.
          valid_d       = 1'b1;
          wr_index_d    = RAZ_IDX;
          wr_data_d     = '0;
          flags_d       = FLAG_WDT'(i_cpsr);
          flag_update_d = 1'b0;
          wr_index_1_d  = head_idx;
          wr_data_1_d   = head_data;
          mem_load_d    = 1'b1;
        end
        if (valid_d && ((wr_index_d == PC_IDX) ||
                        (mem_load_d && (wr_index_1_d == PC_IDX)))) begin
          state_d = ST_WAIT_CLR;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      wr_index_q    <= '0;
      wr_data_q     <= '0;
      flags_q       <= '0;
      flag_update_q <= 1'b0;
      wr_index_1_q  <= '0;
      wr_data_1_q   <= '0;
      mem_load_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      wr_index_q    <= wr_index_d;
      wr_data_q     <= wr_data_d;
      flags_q       <= flags_d;
      flag_update_q <= flag_update_d;
      wr_index_1_q  <= wr_index_1_d;
      wr_data_1_q   <= wr_data_1_d;
      mem_load_q    <= mem_load_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      idx_mem_q[wr_ptr_q]  <= i_b_index;
      data_mem_q[wr_ptr_q] <= i_b_data;
    end
  end

  assign o_valid       = valid_q;
  assign o_wr_index    = wr_index_q;
  assign o_wr_data     = wr_data_q;
  assign o_flags       = flags_q;
  assign o_flag_update = flag_update_q;
  assign o_wr_index_1  = wr_index_1_q;
  assign o_wr_data_1   = wr_data_1_q;
  assign o_mem_load    = mem_load_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_regf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_regf_write_scheduler
// Purpose  : Directed self-checking bench for zap_regf_write_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_regf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, a_flag_update = 1'b0;
  logic [5:0]  a_index = '0, b_index = '0;
  logic [31:0] a_data = '0, a_flags = '0, b_data = '0, cpsr = '0;
  logic        b_valid = 1'b0, stall = 1'b0, clear = 1'b0;
  logic        a_ready, b_ready, valid, flag_update, mem_load;
  logic [5:0]  wr_index, wr_index_1;
  logic [31:0] wr_data, wr_data_1, flags;
  logic [2:0]  pending;

  int n_total = 0;
  int n_bad   = 0;

  zap_regf_write_scheduler dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_index(a_index),
    .i_a_data(a_data), .i_a_flags(a_flags), .i_a_flag_update(a_flag_update),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_index(b_index),
    .i_b_data(b_data), .i_cpsr(cpsr), .i_stall(stall), .i_clear(clear),
    .o_valid(valid), .o_wr_index(wr_index), .o_wr_data(wr_data),
    .o_flags(flags), .o_flag_update(flag_update),
    .o_wr_index_1(wr_index_1), .o_wr_data_1(wr_data_1),
    .o_mem_load(mem_load), .o_pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check_val("rst_valid",    valid, 0);
    check_val("rst_mem_load", mem_load, 0);
    check_val("rst_flag_upd", flag_update, 0);
    check_val("rst_wr_index", wr_index, 0);
    check_val("rst_wr_data",  wr_data, 0);
    check_val("rst_flags",    flags, 0);
    check_val("rst_idx1",     wr_index_1, 0);
    check_val("rst_pending",  pending, 0);
    check_val("rst_a_ready",  a_ready, 1);
    check_val("rst_b_ready",  b_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- A-only ----------------
    a_valid = 1; a_index = 6'd3; a_data = 32'hDEAD_BEEF;
    a_flags = 32'hA000_0000; a_flag_update = 1;
    settle();
    check_val("aonly_a_ready", a_ready, 1);
    tick();
    a_valid = 0; a_flag_update = 0;
    settle();
    check_val("aonly_valid",    valid, 1);
    check_val("aonly_index",    wr_index, 3);
    check_val("aonly_data",     wr_data, 32'hDEAD_BEEF);
    check_val("aonly_mem_load", mem_load, 0);
    check_val("aonly_flags",    flags, 32'hA000_0000);
    check_val("aonly_flag_upd", flag_update, 1);
    tick();
    check_val("aonly_one_shot", valid, 0);

    // ---------------- pairing ----------------
    b_valid = 1; b_index = 6'd5; b_data = 32'h11;
    tick();
    b_valid = 0;
    a_valid = 1; a_index = 6'd7; a_data = 32'h22; a_flags = 32'h1000_0000;
    settle();
    check_val("pair_pending_before", pending, 1);
    check_val("pair_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    settle();
    check_val("pair_valid",    valid, 1);
    check_val("pair_idx0",     wr_index, 7);
    check_val("pair_data0",    wr_data, 32'h22);
    check_val("pair_idx1",     wr_index_1, 5);
    check_val("pair_data1",    wr_data_1, 32'h11);
    check_val("pair_mem_load", mem_load, 1);
    check_val("pair_pending",  pending, 0);

    // ---------------- hazard ----------------
    b_valid = 1; b_index = 6'd4; b_data = 32'h44;
    tick();
    b_valid = 0;
    a_valid = 1; a_index = 6'd4; a_data = 32'h55; cpsr = 32'h6000_001F;
    settle();
    check_val("haz_a_ready", a_ready, 0);
    tick();
    check_val("haz_valid",    valid, 1);
    check_val("haz_idx0_raz", wr_index, 45);
    check_val("haz_data0",    wr_data, 0);
    check_val("haz_flags",    flags, 32'h6000_001F);
    check_val("haz_flag_upd", flag_update, 0);
    check_val("haz_idx1",     wr_index_1, 4);
    check_val("haz_data1",    wr_data_1, 32'h44);
    check_val("haz_mem_load", mem_load, 1);
    check_val("haz_a_ready_after", a_ready, 1);
    tick();
    a_valid = 0;
    settle();
    check_val("haz_a_valid",    valid, 1);
    check_val("haz_a_idx",      wr_index, 4);
    check_val("haz_a_data",     wr_data, 32'h55);
    check_val("haz_a_mem_load", mem_load, 0);

    // ---------------- full FIFO under stall ----------------
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      b_valid = 1; b_index = 6'(8 + k); b_data = 32'h80 + k;
      tick();
    end
    b_valid = 0;
    settle();
    check_val("stall_hold_valid", valid, 1);
    check_val("stall_hold_idx",   wr_index, 4);
    check_val("full_pending",     pending, 4);
    check_val("full_b_ready",     b_ready, 0);
    stall = 0;
    settle();
    check_val("full_b_ready_pop", b_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("drain_valid",   valid, 1);
      check_val("drain_idx0",    wr_index, 45);
      check_val("drain_idx1",    wr_index_1, 6'(8 + k));
      check_val("drain_data1",   wr_data_1, 32'h80 + k);
      check_val("drain_pending", pending, 3 - k);
      check_val("drain_b_ready", b_ready, 1);
    end
    tick();
    check_val("drain_idle", valid, 0);

    // ---------------- PC write ----------------
    b_valid = 1; b_index = 6'd15; b_data = 32'h1000;
    tick();
    b_valid = 0;
    tick();
    check_val("pc_valid",    valid, 1);
    check_val("pc_idx1",     wr_index_1, 15);
    check_val("pc_data1",    wr_data_1, 32'h1000);
    check_val("pc_mem_load", mem_load, 1);
    a_valid = 1; a_index = 6'd2; a_data = 32'h77; a_flags = 32'h0;
    b_valid = 1; b_index = 6'd6; b_data = 32'h66;
    settle();
    check_val("wait_a_ready", a_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      b_valid = 0;
      settle();
      check_val("wait_no_issue", valid, 0);
      check_val("wait_a_ready",  a_ready, 0);
    end
    check_val("wait_pending", pending, 1);
    clear = 1;
    tick();
    clear = 0;
    settle();
    check_val("clr_pending", pending, 0);
    check_val("clr_valid",   valid, 0);
    check_val("clr_a_ready", a_ready, 1);
    tick();
    a_valid = 0;
    settle();
    check_val("run_valid", valid, 1);
    check_val("run_idx",   wr_index, 2);
    check_val("run_data",  wr_data, 32'h77);

    // ---------------- async reset mid-operation ----------------
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1; b_index = 6'(20 + k); b_data = 32'h200 + k;
      tick();
    end
    b_valid = 0;
    settle();
    check_val("prerst_pending", pending, 3);
    check_val("prerst_valid",   valid, 1);
    #1;
    rst_n = 0;
    #1;
    check_val("arst_valid",   valid, 0);
    check_val("arst_pending", pending, 0);
    check_val("arst_idx",     wr_index, 0);
    stall = 0;
    tick();
    rst_n = 1;
    tick();
    check_val("post_rst_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
